// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, command bytes and device responses.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        XFER      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Pad synchronisers for the PS/2 lines: 3-flop clock path with a falling-edge
// strobe and a 2-flop data path. Flops reset high to match the idle bus.
module ps2_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_sync,
    output logic data_sync,
    output logic fall
);

    logic [2:0] clk_sr_r;
    logic [1:0] data_sr_r;

    // Shift the raw pad levels through the synchroniser chains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sr_r  <= 3'b111;
            data_sr_r <= 2'b11;
        end else begin
            clk_sr_r  <= {clk_sr_r[1:0], ps2_clk};
            data_sr_r <= {data_sr_r[0], ps2_data};
        end
    end

    assign clk_sync  = clk_sr_r[1];
    assign data_sync = data_sr_r[1];
    assign fall      = clk_sr_r[2] & ~clk_sr_r[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, issues a request to
// send, shifts one byte out on device clock falls and collects the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);

    localparam int PHASE_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int CW        = $clog2(PHASE_MAX + 1);
    localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] REQ_LAST     = CW'(REQ_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t state_r;
    logic [9:0]    shift_r;
    logic [3:0]    bitcnt_r;
    logic [CW-1:0] phase_cnt_r;
    logic [TW-1:0] tout_r;
    logic          tx_ready_r;
    logic          clk_oe_r;
    logic          data_oe_r;
    logic          done_r;
    logic          ack_ok_r;
    logic          err_r;

    logic          clk_sync_s;
    logic          data_sync_s;
    logic          fall_s;
    logic          timed_s;
    logic          bus_idle_s;
    logic          expire_s;

    ps2_edge_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_sync  (clk_sync_s),
        .data_sync (data_sync_s),
        .fall      (fall_s)
    );

    // Only device-clocked states are guarded; a fall on the terminal count wins.
    assign timed_s    = (state_r == XFER) || (state_r == ACK) || (state_r == WAIT_IDLE);
    assign bus_idle_s = clk_sync_s & data_sync_s;
    assign expire_s   = timed_s && !fall_s && (tout_r == TIMEOUT_LAST)
                        && !((state_r == WAIT_IDLE) && bus_idle_s);

    // Frame sequencer with registered line enables and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            shift_r     <= 10'd0;
            bitcnt_r    <= 4'd0;
            phase_cnt_r <= '0;
            tout_r      <= '0;
            tx_ready_r  <= 1'b1;
            clk_oe_r    <= 1'b0;
            data_oe_r   <= 1'b0;
            done_r      <= 1'b0;
            ack_ok_r    <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            if (expire_s) begin
                state_r    <= IDLE;
                tx_ready_r <= 1'b1;
                clk_oe_r   <= 1'b0;
                data_oe_r  <= 1'b0;
                ack_ok_r   <= 1'b0;
                err_r      <= 1'b1;
                tout_r     <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        clk_oe_r  <= 1'b0;
                        data_oe_r <= 1'b0;
                        if (tx_valid) begin
                            shift_r     <= {1'b1, odd_parity(tx_data), tx_data};
                            phase_cnt_r <= '0;
                            ack_ok_r    <= 1'b0;
                            tx_ready_r  <= 1'b0;
                            clk_oe_r    <= 1'b1;
                            state_r     <= INHIBIT;
                        end else begin
                            tx_ready_r <= 1'b1;
                        end
                    end
                    INHIBIT: begin
                        if (phase_cnt_r == INHIBIT_LAST) begin
                            phase_cnt_r <= '0;
                            data_oe_r   <= 1'b1;
                            state_r     <= REQ;
                        end else begin
                            phase_cnt_r <= phase_cnt_r + CW'(1);
                        end
                    end
                    REQ: begin
                        if (phase_cnt_r == REQ_LAST) begin
                            phase_cnt_r <= '0;
                            bitcnt_r    <= 4'd0;
                            tout_r      <= '0;
                            clk_oe_r    <= 1'b0;
                            state_r     <= XFER;
                        end else begin
                            phase_cnt_r <= phase_cnt_r + CW'(1);
                        end
                    end
                    XFER: begin
                        if (fall_s) begin
                            data_oe_r <= ~shift_r[0];
                            shift_r   <= {1'b0, shift_r[9:1]};
                            bitcnt_r  <= bitcnt_r + 4'd1;
                            tout_r    <= '0;
                            if (bitcnt_r == 4'd9) begin
                                state_r <= ACK;
                            end else begin
                                state_r <= XFER;
                            end
                        end else begin
                            tout_r <= tout_r + TW'(1);
                        end
                    end
                    ACK: begin
                        if (fall_s) begin
                            ack_ok_r <= ~data_sync_s;
                            tout_r   <= '0;
                            state_r  <= WAIT_IDLE;
                        end else begin
                            tout_r <= tout_r + TW'(1);
                        end
                    end
                    WAIT_IDLE: begin
                        if (bus_idle_s) begin
                            done_r     <= 1'b1;
                            tx_ready_r <= 1'b1;
                            tout_r     <= '0;
                            state_r    <= IDLE;
                        end else if (fall_s) begin
                            tout_r <= '0;
                        end else begin
                            tout_r <= tout_r + TW'(1);
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        tx_ready_r <= 1'b1;
                        clk_oe_r   <= 1'b0;
                        data_oe_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = tx_ready_r;
    assign ps2_clk_oe  = clk_oe_r;
    assign ps2_data_oe = data_oe_r;
    assign done        = done_r;
    assign ack_ok      = ack_ok_r;
    assign err         = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural keyboard clocks frames out of the
// host and a vector table holds the hand-computed frame bits and ACK results.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int REQ  = 4;
    localparam int TOUT = 400;
    localparam int H    = 10;

    typedef struct {
        logic [7:0]  data;
        logic        dev_ack;
        logic        inject;
        logic [10:0] frame;
        logic        ack_ok;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, done, ack_ok, err;

    wire ps2_clk_w  = ~ps2_clk_oe & dev_clk;
    wire ps2_data_w = ~ps2_data_oe & dev_data;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    vec_t vecs[5];

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (REQ),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk_w),
        .ps2_data    (ps2_data_w),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .done        (done),
        .ack_ok      (ack_ok),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hand a byte to the host and measure how long it holds the clock line.
    task automatic start_frame(input logic [7:0] b, output int hi, output int rise);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
        check("ack_ok_clear_on_accept", {31'd0, ack_ok}, 32'd0);
        hi   = 0;
        rise = -1;
        for (int n = 0; n < INH + REQ + 20; n++) begin
            if (!ps2_clk_oe) break;
            if (ps2_data_oe && rise < 0) rise = n;
            hi++;
            @(negedge clk);
        end
    endtask

    // Keyboard model: samples each bit while the clock is high, then clocks it.
    task automatic device(input logic ack, input logic inject, input int nclk, output logic [10:0] bits);
        bits = 11'd0;
        for (int k = 0; k < nclk; k++) begin
            repeat (H) @(negedge clk);
            bits[k] = ps2_data_w;
            if (inject && k == 4) begin
                check("busy_not_ready", {31'd0, tx_ready}, 32'd0);
                tx_valid = 1'b1;
                tx_data  = 8'h55;
                @(negedge clk);
                tx_valid = 1'b0;
            end
            if (k == 10 && ack) dev_data = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int hi, rise, d0, e0;
        logic [10:0] bits;
        check("ready_before_frame", {31'd0, tx_ready}, 32'd1);
        d0 = done_cnt;
        e0 = err_cnt;
        start_frame(v.data, hi, rise);
        check("clk_oe_cycles", hi, INH + REQ);
        check("data_oe_rise_cycle", rise, INH);
        device(v.dev_ack, v.inject, 11, bits);
        check("frame_bits", {21'd0, bits}, {21'd0, v.frame});
        repeat (H) @(negedge clk);
        dev_data = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (done_cnt != d0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("err_pulses", err_cnt - e0, 0);
        check("ack_ok", {31'd0, ack_ok}, {31'd0, v.ack_ok});
        check("ready_after_frame", {31'd0, tx_ready}, 32'd1);
        check("lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    initial begin
        int hi, rise, got, d0, e0;
        logic [10:0] bits;
        vec_t vf;

        vecs[0] = '{ps2_pkg::CMD_SET_LED, 1'b1, 1'b0, 11'b1_1_1110_1101_0, 1'b1};
        vecs[1] = '{8'h01,                1'b1, 1'b0, 11'b1_0_0000_0001_0, 1'b1};
        vecs[2] = '{ps2_pkg::CMD_RESET,   1'b1, 1'b0, 11'b1_1_1111_1111_0, 1'b1};
        vecs[3] = '{ps2_pkg::CMD_SET_LED, 1'b0, 1'b0, 11'b1_1_1110_1101_0, 1'b0};
        vecs[4] = '{ps2_pkg::CMD_SET_LED, 1'b1, 1'b1, 11'b1_1_1110_1101_0, 1'b1};
        vf      = '{ps2_pkg::CMD_ENABLE,  1'b1, 1'b0, 11'b1_0_1111_0100_0, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_outputs", {26'd0, tx_ready, ps2_clk_oe, ps2_data_oe, done, ack_ok, err}, 32'h20);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outputs", {26'd0, tx_ready, ps2_clk_oe, ps2_data_oe, done, ack_ok, err}, 32'h20);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Device never clocks: the host must give up after the timeout.
        d0 = done_cnt;
        e0 = err_cnt;
        start_frame(ps2_pkg::CMD_RESET, hi, rise);
        got = -1;
        for (int n = 1; n <= TOUT + 50; n++) begin
            @(negedge clk);
            if (err) begin
                got = n;
                break;
            end
        end
        check("timeout_cycles", got, TOUT);
        check("timeout_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("timeout_ack_ok", {31'd0, ack_ok}, 32'd0);
        repeat (3) @(negedge clk);
        check("timeout_ready", {31'd0, tx_ready}, 32'd1);
        check("timeout_err_pulses", err_cnt - e0, 1);
        check("timeout_no_done", done_cnt - d0, 0);

        // Reset in the middle of the data bits.
        d0 = done_cnt;
        e0 = err_cnt;
        start_frame(ps2_pkg::CMD_ENABLE, hi, rise);
        device(1'b1, 1'b0, 4, bits);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("reset_mid_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_mid_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_mid_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        run_vec(vf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
